pixel_writer: RTL
=================

Name: pixel_writer

Overview:
- Downstream of the fractal pixel generator and its divergence pipeline; writes finished pixels into the video framebuffer.
- Realigns each issued pixel address with its iteration result after the fixed pipeline latency.
- Maps the 8-bit iteration count to an RGB332 colour and issues one framebuffer write per valid pixel.
- Counts writes and tells the display side when a full frame is complete.

Parameters:
- PIPE_DEPTH, 63, cycles from issue_valid/issue_addr to the matching div_in at the pipeline output
- H_RES, 640, pixels per row
- V_RES, 480, rows per frame
- INSET_CODE, 8'd0, div_in value meaning "did not diverge" (drawn black)

Ports:
- Clk_100M  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins or restarts a frame
- issue_valid  in  1  pulse when a new pixel enters the divergence pipeline
- issue_addr  in  19  framebuffer address of that pixel (row*H_RES+col)
- div_in  in  8  iteration result at the pipeline output
- fb_addr  out  19  framebuffer write address
- fb_data  out  8  RGB332 pixel colour
- fb_we  out  1  framebuffer write enable, one cycle per pixel
- frame_done  out  1  single-cycle pulse when the last pixel of the frame is written
- display  out  1  level, high once a frame is complete; cleared by start
- addr_err  out  1  sticky flag: a realigned address was >= H_RES*V_RES

Behaviour:
- Reset state (asynchronous, reset low):
  - fb_addr=0, fb_data=0, fb_we=0, frame_done=0, display=0, addr_err=0.
  - Write counter=0, delay line cleared, FSM=IDLE.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on start.
  - RUN -> DONE when the write counter reaches H_RES*V_RES.
  - DONE -> RUN on start.
  - start while in RUN restarts the frame: counter cleared, delay-line valid bits cleared the same cycle, so in-flight pixels from the old frame never write.
  - start also clears display and addr_err.
- Delay line:
  - PIPE_DEPTH-stage shift register of {valid, addr[18:0]}, shifting every cycle.
  - issue_valid is entered only in RUN, or in the same cycle as start. Otherwise a 0 valid bit is shifted in.
- Write stage (registered): when the delay-line output valid=1 and FSM=RUN, on the next edge:
  - fb_we=1 and fb_addr=the delayed address.
  - fb_data = 8'h00 if div_in==INSET_CODE, else {div_in[2:0], div_in[5:3], div_in[7:6]}. div_in is sampled in the cycle the delay-line output valid is high.
  - Otherwise fb_we=0; fb_addr and fb_data hold their last values.
- Latency: issue_valid at cycle t gives fb_we at cycle t+PIPE_DEPTH+1. Throughput is one pixel per cycle (upstream issues one per 6 cycles).
- Out-of-range address (>= H_RES*V_RES): the write is suppressed (fb_we=0), addr_err is set, and the pixel is not counted.
- Counter:
  - 19-bit; increments on each fb_we.
  - When it reaches H_RES*V_RES: frame_done pulses the next cycle, display goes high, FSM enters DONE, and further realigned valids are ignored.
  - Duplicate addresses are counted; the block does not deduplicate.
- Simultaneous start and final write: start wins. Counter=0, no frame_done, state RUN.
- Reset mid-frame: everything returns to reset values; no partial write completes.

Decomposition:
- Shared package fractal_pkg:
  - H_RES, V_RES, FB_ADDR_W=19, PIX_W=8, FRAME_PIXELS=H_RES*V_RES.
  - Palette bit-slice function and INSET_CODE.
- One sub-module, valid_delay: a parameterised {valid,data} shift register (DEPTH, WIDTH) with synchronous flush and asynchronous active-low reset; reused for any later pipeline-alignment need.

Test Plan:
- Latency, PIPE_DEPTH=63: start, then issue_valid with issue_addr=19'd1000 at cycle 10 → fb_we high at cycle 74 only, fb_addr=1000.
- Palette: div_in=8'b10_110_011 at realign → fb_data=8'b011_110_10. div_in=INSET_CODE (0) → fb_data=8'h00.
- Full frame, H_RES=4, V_RES=2, PIPE_DEPTH=3: issue addresses 0..7 every 6 cycles → 8 writes; frame_done pulses once after the 8th; display=1; a 9th issue produces no fb_we.
- Restart flush: issue 3 pixels, pulse start 2 cycles later → none of the 3 writes; counter=0; display=0.
- Out-of-range, small config: issue_addr=8 → fb_we stays 0, addr_err=1 and stays high until start; counter unchanged.
- Async reset mid-frame: assert reset low between clock edges with pixels in flight → outputs zero immediately; after release with no start, no fb_we for 100 cycles.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared constants, FSM encoding and colour mapping for the fractal renderer back end.
package fractal_pkg;

    localparam int unsigned H_RES        = 640;
    localparam int unsigned V_RES        = 480;
    localparam int unsigned FB_ADDR_W    = 19;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned FRAME_PIXELS = H_RES * V_RES;

    localparam logic [PIX_W-1:0] INSET_CODE = 8'd0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } wr_state_e;

    // Iteration count to RGB332; points that never diverged are drawn black.
    function automatic logic [PIX_W-1:0] palette(input logic [PIX_W-1:0] iter,
                                                 input logic [PIX_W-1:0] inset);
        if (iter == inset) begin
            return '0;
        end
        return {iter[2:0], iter[5:3], iter[7:6]};
    endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-latency {valid, data} shift register for realigning side-band data with a pipeline.
module valid_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;

    // Flush drops everything already in flight but still takes the entry presented this cycle.
    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = valid_i;
        dat_d[0] = data_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush_i;
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/pixel_writer.sv
// Realigns issued pixel addresses with divergence results and writes RGB332 pixels to the
// framebuffer, tracking frame completion.
module pixel_writer #(
    parameter int unsigned PIPE_DEPTH = 63,
    parameter int unsigned H_RES      = fractal_pkg::H_RES,
    parameter int unsigned V_RES      = fractal_pkg::V_RES,
    parameter logic [7:0]  INSET_CODE = fractal_pkg::INSET_CODE
) (
    input  logic        Clk_100M,
    input  logic        reset,
    input  logic        start,
    input  logic        issue_valid,
    input  logic [18:0] issue_addr,
    input  logic [7:0]  div_in,
    output logic [18:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_we,
    output logic        frame_done,
    output logic        display,
    output logic        addr_err
);

    import fractal_pkg::*;

    localparam logic [FB_ADDR_W-1:0] FRAME_END = FB_ADDR_W'(H_RES * V_RES);

    wr_state_e            state_q, state_d;
    logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]     fb_data_q, fb_data_d;
    logic                 fb_we_q, fb_we_d;
    logic                 frame_done_q, frame_done_d;
    logic                 display_q, display_d;
    logic                 addr_err_q, addr_err_d;

    logic                 accept;
    logic                 dly_valid;
    logic [FB_ADDR_W-1:0] dly_addr;

    // A pixel issued alongside start belongs to the new frame.
    assign accept = issue_valid & (start | (state_q == StRun));

    valid_delay #(
        .DEPTH (PIPE_DEPTH),
        .WIDTH (FB_ADDR_W)
    ) u_delay (
        .clk_i   (Clk_100M),
        .rst_ni  (reset),
        .flush_i (start),
        .valid_i (accept),
        .data_i  (issue_addr),
        .valid_o (dly_valid),
        .data_o  (dly_addr)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_we_d      = 1'b0;
        frame_done_d = 1'b0;
        display_d    = display_q;
        addr_err_d   = addr_err_q;

        if (start) begin
            // Restart beats any write or completion landing in the same cycle.
            state_d    = StRun;
            cnt_d      = '0;
            display_d  = 1'b0;
            addr_err_d = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (cnt_q == FRAME_END) begin
                        state_d      = StDone;
                        frame_done_d = 1'b1;
                        display_d    = 1'b1;
                    end else if (dly_valid) begin
                        if (dly_addr >= FRAME_END) begin
                            addr_err_d = 1'b1;
                        end else begin
                            fb_we_d   = 1'b1;
                            fb_addr_d = dly_addr;
                            fb_data_d = palette(div_in, INSET_CODE);
                            cnt_d     = cnt_q + 19'd1;
                        end
                    end
                end
                StIdle, StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk_100M or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            display_q    <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            frame_done_q <= frame_done_d;
            display_q    <= display_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign frame_done = frame_done_q;
    assign display    = display_q;
    assign addr_err   = addr_err_q;

endmodule
